// File: rtl/pipe_stage_reg.sv
// Pipeline stage register: valid/ready handshake, synchronous flush, saturating stall counter.
// Latency: in-fire in cycle N presents the entry on out_valid/out_data in cycle N+1 (registered outputs).
// Backpressure: with PIPE_STAGE_REG_SKID_EN, two-entry skid and registered in_ready = ~skid_v; without it, in_ready = ~main_v | out_ready.
module pipe_stage_reg #(
  parameter int unsigned      WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}},
  parameter int unsigned      CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] stall_cnt,
  input  logic             stall_clr
);

  // State is the pair of valid bits: bit0 = main_v, bit1 = skid_v.
  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    FULL  = 2'b01,
    SKID  = 2'b11
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] main_q;
  logic             main_v;
  logic             in_fire;
  logic             out_fire;
  logic             load_in;

  assign main_v   = state_q[0];
  assign in_fire  = in_valid & in_ready;
  assign out_fire = main_v & out_ready;

`ifdef PIPE_STAGE_REG_SKID_EN
  logic [WIDTH-1:0] skid_q;
  logic             skid_v;
  logic             load_skid;
  logic             load_from_skid;

  assign skid_v   = state_q[1];
  // Only the skid entry blocks upstream, so in_ready never depends on out_ready.
  assign in_ready = ~skid_v;
`else
  // Single entry: a full stage can accept only when the head leaves this cycle.
  assign in_ready = ~main_v | out_ready;
`endif

  // Next-state and load selection; flush overrides everything and rewrites no data.
  always_comb begin
    state_d = state_q;
    load_in = 1'b0;
`ifdef PIPE_STAGE_REG_SKID_EN
    load_skid      = 1'b0;
    load_from_skid = 1'b0;
`endif
    case (state_q)
      EMPTY: begin
        if (in_fire) begin
          state_d = FULL;
          load_in = 1'b1;
        end
      end
      FULL: begin
        if (in_fire && out_fire) begin
          load_in = 1'b1;
`ifdef PIPE_STAGE_REG_SKID_EN
        end else if (in_fire) begin
          state_d   = SKID;
          load_skid = 1'b1;
`endif
        end else if (out_fire) begin
          state_d = EMPTY;
        end
      end
`ifdef PIPE_STAGE_REG_SKID_EN
      SKID: begin
        if (out_fire) begin
          state_d        = FULL;
          load_from_skid = 1'b1;
        end
      end
`endif
      default: state_d = EMPTY;
    endcase
    if (flush) begin
      state_d = EMPTY;
      load_in = 1'b0;
`ifdef PIPE_STAGE_REG_SKID_EN
      load_skid      = 1'b0;
      load_from_skid = 1'b0;
`endif
    end
  end

  // State register; reset drops every held entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= EMPTY;
    else      state_q <= state_d;
  end

  // Head payload: from upstream, or promoted from the skid slot when the head drains.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      main_q <= RESET_VAL;
    end else if (load_in) begin
      main_q <= in_data;
`ifdef PIPE_STAGE_REG_SKID_EN
    end else if (load_from_skid) begin
      main_q <= skid_q;
`endif
    end
  end

`ifdef PIPE_STAGE_REG_SKID_EN
  // Skid payload: captures the entry accepted while the head is stalled.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)           skid_q <= RESET_VAL;
    else if (load_skid) skid_q <= in_data;
  end
`endif

  // Stall counter: clear wins, then saturating increment on stalled cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                          stall_cnt <= '0;
    else if (stall_clr)                                stall_cnt <= '0;
    else if (main_v && !out_ready && stall_cnt != CNT_MAX) stall_cnt <= stall_cnt + CNT_W'(1);
  end

  assign out_valid = main_v;
  assign out_data  = main_q;

endmodule
